// File: rtl/int_fp_mul_bist.sv
// int_fp_mul_bist: pattern-ROM driven self-test for int_fp_mul with latency-aligned result checking.
// Define INT_FP_MUL_BIST_TRACE_EN to add err_expected/err_actual/err_mode capture of the first mismatch.
//   state | meaning
//   IDLE  | waiting for start after reset
//   RUN   | issuing pattern addresses 0..PATTERN_NUM-1, one per cycle
//   DRAIN | all addresses issued, waiting for outstanding compares
//   DONE  | results held until the next start
module int_fp_mul_bist #(
    parameter int PATTERN_NUM = 20,
    parameter int ADDR_W      = 5,
    parameter int MUL_LATENCY = 1,
    parameter int ERR_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] pat_addr,
    input  logic [48:0]       pat_data,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    output logic              mul_mode,
    input  logic [15:0]       mul_result,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  error_cnt,
    output logic [ADDR_W-1:0] first_err_idx
`ifdef INT_FP_MUL_BIST_TRACE_EN
    ,
    output logic [15:0]       err_expected,
    output logic [15:0]       err_actual,
    output logic [0:0]        err_mode
`endif
);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PATTERN_NUM - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX   = '1;

    state_t                 state;
    logic                   iss_vld;
    logic                   cmp_miss;
    logic [MUL_LATENCY-1:0] dly_vld;
    logic [15:0]            dly_exp [MUL_LATENCY];
    logic [ADDR_W-1:0]      dly_idx [MUL_LATENCY];
`ifdef INT_FP_MUL_BIST_TRACE_EN
    logic [MUL_LATENCY-1:0] dly_mode;
`endif

    // ROM word for the address on pat_addr is present by the next edge, so RUN cycles are issue slots.
    assign iss_vld  = (state == ST_RUN);
    assign cmp_miss = dly_vld[MUL_LATENCY-1] && (mul_result != dly_exp[MUL_LATENCY-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_a    <= '0;
            mul_b    <= '0;
            mul_mode <= 1'b0;
            dly_vld  <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                dly_exp[i] <= '0;
                dly_idx[i] <= '0;
            end
`ifdef INT_FP_MUL_BIST_TRACE_EN
            dly_mode <= '0;
`endif
        end else begin
            if (iss_vld) begin
                mul_a    <= pat_data[48:33];
                mul_b    <= pat_data[32:17];
                mul_mode <= pat_data[0];
            end
            dly_vld[0] <= iss_vld;
            dly_exp[0] <= pat_data[16:1];
            dly_idx[0] <= pat_addr;
            for (int i = 1; i < MUL_LATENCY; i++) begin
                dly_vld[i] <= dly_vld[i-1];
                dly_exp[i] <= dly_exp[i-1];
                dly_idx[i] <= dly_idx[i-1];
            end
`ifdef INT_FP_MUL_BIST_TRACE_EN
            dly_mode[0] <= pat_data[0];
            for (int i = 1; i < MUL_LATENCY; i++) begin
                dly_mode[i] <= dly_mode[i-1];
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            pat_addr      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            error_cnt     <= '0;
            first_err_idx <= '0;
`ifdef INT_FP_MUL_BIST_TRACE_EN
            err_expected  <= '0;
            err_actual    <= '0;
            err_mode      <= '0;
`endif
        end else begin
            // error_cnt is zero until the first mismatch of a run, so it doubles as the first-error flag
            if (cmp_miss) begin
                if (error_cnt != ERR_MAX) error_cnt <= error_cnt + 1'b1;
                if (error_cnt == '0) begin
                    first_err_idx <= dly_idx[MUL_LATENCY-1];
`ifdef INT_FP_MUL_BIST_TRACE_EN
                    err_expected  <= dly_exp[MUL_LATENCY-1];
                    err_actual    <= mul_result;
                    err_mode      <= dly_mode[MUL_LATENCY-1];
`endif
                end
            end
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_RUN;
                        pat_addr      <= '0;
                        error_cnt     <= '0;
                        first_err_idx <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
`ifdef INT_FP_MUL_BIST_TRACE_EN
                        err_expected  <= '0;
                        err_actual    <= '0;
                        err_mode      <= '0;
`endif
                    end
                end
                ST_RUN: begin
                    if (pat_addr == LAST_ADDR) state <= ST_DRAIN;
                    else                       pat_addr <= pat_addr + 1'b1;
                end
                ST_DRAIN: begin
                    if (dly_vld == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (error_cnt == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/int_fp_mul_bist.md
Name: int_fp_mul_bist

Overview:
- Synthesizable on-chip pattern driver and result checker for int_fp_mul.
- Reads packed golden words {input1[15:0], input2[15:0], expected[15:0], mode} from a synchronous pattern ROM and drives the multiplier one operand pair per cycle.
- Aligns each expected value to the multiplier's pipeline latency, compares it with the returned result, and reports an error count and pass/fail.
- Sits beside int_fp_mul as its stimulus/response end for silicon and FPGA self-test.

Parameters:
- PATTERN_NUM, 20, number of pattern words checked per run (1..2^ADDR_W).
- ADDR_W, 5, pattern ROM address width.
- MUL_LATENCY, 1, clock edges from operands launched on mul_a/mul_b/mul_mode to mul_result valid (1..8).
- ERR_W, 8, error counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- pat_addr  out  ADDR_W  pattern ROM address.
- pat_data  in  49  ROM word; bits 48:33 input1, 32:17 input2, 16:1 expected, 0 mode; valid 1 cycle after pat_addr.
- mul_a  out  16  operand 1 to int_fp_mul.
- mul_b  out  16  operand 2 to int_fp_mul.
- mul_mode  out  1  mode to int_fp_mul.
- mul_result  in  16  int_fp_mul result.
- busy  out  1  run in progress.
- done  out  1  run complete; held until the next start or reset.
- pass  out  1  done and error_cnt==0.
- error_cnt  out  ERR_W  mismatch count, saturating.
- first_err_idx  out  ADDR_W  pattern index of the first mismatch; 0 if none.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - Issue, valid and expected pipelines cleared.
- Synchronous reset asserted mid-run aborts immediately. No partial result is retained.
- FSM states:
  - IDLE: start -> RUN. pat_addr<=0, error_cnt<=0, first_err_idx<=0, done<=0, busy<=1.
  - RUN:
    - Issue one address per cycle, pat_addr 0..PATTERN_NUM-1.
    - After issuing PATTERN_NUM-1 -> DRAIN.
  - DRAIN: wait until the compare-valid pipeline is empty -> DONE.
  - DONE:
    - busy<=0, done<=1, pass<=(error_cnt==0).
    - start -> RUN, with the same clears as from IDLE.
- start while busy is ignored.
- Pipeline timing for pattern k, where address k is issued at edge T:
  - T+1: pat_data valid; registered into mul_a/mul_b/mul_mode; expected and index k enter a delay line with valid=1.
  - T+1+MUL_LATENCY: mul_result compared against the delayed expected.
  - Total issue-to-compare latency: MUL_LATENCY+1 cycles.
- Throughput: one pattern per cycle; no bubbles.
- Total run: PATTERN_NUM+MUL_LATENCY+1 cycles in RUN+DRAIN, then DONE.
- Operand hold: mul_a/mul_b/mul_mode hold their last value after RUN; they do not return to 0.
- Compare rule: exact 16-bit equality; only slots with valid=1 are compared.
- Error accounting:
  - Each mismatch increments error_cnt; saturates at 2^ERR_W-1, no wrap.
  - first_err_idx is captured on the first mismatch of a run only.
- PATTERN_NUM==1: RUN lasts one cycle, then DRAIN.

Optional Feature:
- Macro: INT_FP_MUL_BIST_TRACE_EN.
- When defined:
  - Adds output ports err_expected[15:0], err_actual[15:0] and err_mode[0:0].
  - These capture the expected value, mul_result and mode of the first mismatch.
  - All three are cleared on reset and on start.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Test Plan:
- All-match, 20 patterns, MUL_LATENCY=1: reference model echoes expected -> done rises exactly 22 cycles after start is sampled; pass=1, error_cnt=0.
- Single mismatch at index 7: model returns 16'h3C01 vs expected 16'h3C00 -> error_cnt=1, first_err_idx=7, pass=0; with TRACE_EN, err_expected=16'h3C00, err_actual=16'h3C01.
- Saturation, ERR_W=2, all 20 patterns wrong -> error_cnt=3, no wrap, pass=0.
- Latency sweep, MUL_LATENCY=3, model delays exactly 3: all pass, run takes 24 cycles; same model with MUL_LATENCY=2 -> nonzero error_cnt.
- reset asserted at RUN cycle 10 -> next edge: busy=0, done=0, error_cnt=0, pat_addr=0; a new start completes a full run correctly.
- start pulsed during RUN is ignored (pat_addr sequence unbroken); start in DONE reruns and clears done for the run duration.
